// File: rtl/if_id_pipeline_register_pkg.sv
// ----------------------------------------------------------------------------
// if_id_pipeline_register_pkg
//   Shared constants for the IF/ID pipeline boundary: the bubble instruction,
//   the default event-counter width and the MIPS field bit positions used by
//   both the register and its decode slices.
// ----------------------------------------------------------------------------
package if_id_pipeline_register_pkg;

   // sll $0,$0,0 -- architecturally a no-op, used as the pipeline bubble
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
   localparam int          CNT_W_DEFAULT     = 16;

   // MIPS instruction field positions
   localparam int OPC_HI = 31, OPC_LO = 26;
   localparam int RS_HI  = 25, RS_LO  = 21;
   localparam int RT_HI  = 20, RT_LO  = 16;
   localparam int RD_HI  = 15, RD_LO  = 11;
   localparam int SH_HI  = 10, SH_LO  = 6;
   localparam int FN_HI  = 5,  FN_LO  = 0;
   localparam int IMM_HI = 15, IMM_LO = 0;
   localparam int JIDX_HI = 25, JIDX_LO = 0;

   // Upper PC bits kept by a J-type target (the current 256 MB region)
   localparam int PC_SEG_HI = 31, PC_SEG_LO = 28;

   // Sign-extend the 16-bit immediate of an instruction word
   function automatic logic [31:0] imm_sext16(input logic [31:0] instr);
      return {{16{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
   endfunction

   // Zero-extend the 16-bit immediate of an instruction word
   function automatic logic [31:0] imm_zext16(input logic [31:0] instr);
      return {16'h0000, instr[IMM_HI:IMM_LO]};
   endfunction

endpackage

// File: rtl/if_id_pipeline_register_if.sv
// ----------------------------------------------------------------------------
// if_id_pipeline_register_if
//   Bundle between fetch / hazard control and the IF/ID register, plus the
//   decode-facing outputs.
//   master : fetch side  -- drives pc_in, instr_in, Stall, Flush
//   slave  : IF/ID reg   -- drives pc_out, instr_out, valid_out, decoded
//                           fields, jump_target and both event counters
// ----------------------------------------------------------------------------
interface if_id_pipeline_register_if
   import if_id_pipeline_register_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
);

   // Fetch / hazard side
   logic [31:0]      pc_in;
   logic [31:0]      instr_in;
   logic             Stall;
   logic             Flush;

   // Decode side
   logic [31:0]      pc_out;
   logic [31:0]      instr_out;
   logic             valid_out;
   logic [5:0]       opcode;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       rd;
   logic [4:0]       shamt;
   logic [5:0]       funct;
   logic [31:0]      imm_sext;
   logic [31:0]      imm_zext;
   logic [31:0]      jump_target;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output pc_in, instr_in, Stall, Flush,
      input  pc_out, instr_out, valid_out, opcode, rs, rt, rd, shamt, funct,
             imm_sext, imm_zext, jump_target, stall_count, flush_count
   );

   modport slave (
      input  pc_in, instr_in, Stall, Flush,
      output pc_out, instr_out, valid_out, opcode, rs, rt, rd, shamt, funct,
             imm_sext, imm_zext, jump_target, stall_count, flush_count
   );

endinterface

// File: rtl/if_id_pipeline_register_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   W-bit up-counter that sticks at all-ones instead of wrapping.
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high; clears the count and wins over inc
//   inc   : count one event this cycle
//   count : current value
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;
   logic         w_at_max;

   assign w_at_max = (r_count == {W{1'b1}});

   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_count <= '0;
      end else if (inc && !w_at_max) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/if_id_pipeline_register.sv
// ----------------------------------------------------------------------------
// if_id_pipeline_register
//   IF/ID pipeline boundary. Captures PC+4 and the fetched instruction each
//   edge, holds on Stall, inserts a NOP bubble on Flush (Flush beats Stall),
//   and presents pre-split MIPS fields, immediates and the J-type target.
//   Saturating counters track stalled cycles and flush events.
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high
//   bus   : slave side of if_id_pipeline_register_if (fetch inputs,
//           registered outputs, decoded fields, event counters)
// ----------------------------------------------------------------------------
module if_id_pipeline_register
   import if_id_pipeline_register_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
   parameter int          CNT_W     = CNT_W_DEFAULT
) (
   input  logic                        Clk,
   input  logic                        Reset,
   if_id_pipeline_register_if.slave    bus
);

   logic [31:0]      r_pc;
   logic [31:0]      r_instr;
   logic             r_valid;

   logic             w_stall_inc;
   logic             w_flush_inc;
   logic [CNT_W-1:0] w_stall_count;
   logic [CNT_W-1:0] w_flush_count;

   // Priority: Reset > Flush > Stall > load
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_pc    <= 32'h0;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (bus.Flush) begin
         // Bubble keeps the PC so downstream debug can see where it came from
         r_pc    <= bus.pc_in;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (!bus.Stall) begin
         r_pc    <= bus.pc_in;
         r_instr <= bus.instr_in;
         r_valid <= 1'b1;
      end
   end

   // A stall that coincides with a flush is not a stalled cycle
   assign w_stall_inc = bus.Stall && !bus.Flush;
   assign w_flush_inc = bus.Flush;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .inc   (w_stall_inc),
      .count (w_stall_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .inc   (w_flush_inc),
      .count (w_flush_count)
   );

   // Registered outputs
   assign bus.pc_out      = r_pc;
   assign bus.instr_out   = r_instr;
   assign bus.valid_out   = r_valid;
   assign bus.stall_count = w_stall_count;
   assign bus.flush_count = w_flush_count;

   // Decode slices of the registered word -- no added latency
   assign bus.opcode      = r_instr[OPC_HI:OPC_LO];
   assign bus.rs          = r_instr[RS_HI:RS_LO];
   assign bus.rt          = r_instr[RT_HI:RT_LO];
   assign bus.rd          = r_instr[RD_HI:RD_LO];
   assign bus.shamt       = r_instr[SH_HI:SH_LO];
   assign bus.funct       = r_instr[FN_HI:FN_LO];
   assign bus.imm_sext    = imm_sext16(r_instr);
   assign bus.imm_zext    = imm_zext16(r_instr);
   assign bus.jump_target = {r_pc[PC_SEG_HI:PC_SEG_LO], r_instr[JIDX_HI:JIDX_LO], 2'b00};

endmodule
